// File: rtl/lsu_wb_queue_if.sv
// Bus bundle between EX, the load/store writeback queue and the register-file write port.
// Signal names are written from the queue's point of view.
interface lsu_wb_queue_if #(
  parameter int CNT_W = 2
);
  logic             push_i;
  logic             push_we_i;
  logic [4:0]       push_waddr_i;
  logic [1:0]       push_type_i;
  logic             push_sign_ext_i;
  logic [1:0]       push_offset_i;
  logic             push_ready_o;
  logic             flush_i;
  logic             rvalid_i;
  logic [31:0]      rdata_i;
  logic             wb_we_o;
  logic [4:0]       wb_waddr_o;
  logic [31:0]      wb_wdata_o;
  logic [CNT_W-1:0] count_o;
  logic             busy_o;
  logic             resp_err_o;

  modport master (
    output push_i, push_we_i, push_waddr_i, push_type_i, push_sign_ext_i, push_offset_i,
    output flush_i, rvalid_i, rdata_i,
    input  push_ready_o, wb_we_o, wb_waddr_o, wb_wdata_o, count_o, busy_o, resp_err_o
  );

  modport slave (
    input  push_i, push_we_i, push_waddr_i, push_type_i, push_sign_ext_i, push_offset_i,
    input  flush_i, rvalid_i, rdata_i,
    output push_ready_o, wb_we_o, wb_waddr_o, wb_wdata_o, count_o, busy_o, resp_err_o
  );
endinterface

// File: rtl/lsu_wb_queue.sv
// In-order queue of outstanding data-memory requests; aligns/extends load data for writeback.
// Optional macro LSU_WB_BYPASS_EN: writeback and resp_err_o become combinational (latency 0).
module lsu_wb_queue #(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input logic          clk,
  input logic          rst_n,
  lsu_wb_queue_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PW-1:0]    LAST_C  = PW'(DEPTH - 1);

  typedef struct packed {
    logic       we;
    logic [4:0] waddr;
    logic [1:0] typ;
    logic       sext;
    logic [1:0] off;
  } entry_t;

  entry_t           ent_q [DEPTH];
  logic [DEPTH-1:0] kill_q, kill_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [4:0]       wb_waddr_q;
  logic [31:0]      wb_wdata_q, load_data;
  logic             push_ok, pop, err, head_kill, wr_en;
  entry_t           head, new_ent;

  function automatic logic [31:0] align_load(input logic [31:0] data, input logic [1:0] typ,
                                             input logic sext, input logic [1:0] off);
    logic [63:0]        dbl;
    logic [31:0]        rot;
    logic signed [15:0] h;
    logic signed [7:0]  b;
    dbl = {data, data} >> {off, 3'b000};
    rot = dbl[31:0];
    h   = rot[15:0];
    b   = rot[7:0];
    if (typ == 2'b00)
      return rot;
    else if (typ == 2'b01)
      return {{16{sext & h[15]}}, h};
    else
      return {{24{sext & b[7]}}, b};
  endfunction

  always_comb begin
    head      = ent_q[rd_ptr_q];
    push_ok   = bus.push_i & (count_q < DEPTH_C);
    pop       = bus.rvalid_i & (count_q != '0);
    err       = bus.rvalid_i & (count_q == '0);
    // A flush in the pop cycle kills the head too
    head_kill = kill_q[rd_ptr_q] | bus.flush_i;
    wr_en     = pop & head.we & ~head_kill;
    load_data = align_load(bus.rdata_i, head.typ, head.sext, head.off);

    new_ent.we    = bus.push_we_i;
    new_ent.waddr = bus.push_waddr_i;
    new_ent.typ   = bus.push_type_i;
    new_ent.sext  = bus.push_sign_ext_i;
    new_ent.off   = bus.push_offset_i;

    kill_d = bus.flush_i ? '1 : kill_q;
    if (push_ok)
      kill_d[wr_ptr_q] = 1'b0;

    wr_ptr_d = wr_ptr_q;
    if (push_ok)
      wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
    rd_ptr_d = rd_ptr_q;
    if (pop)
      rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;

    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Entry payload needs no reset: kill bits and count gate every use
  always_ff @(posedge clk) begin
    if (push_ok)
      ent_q[wr_ptr_q] <= new_ent;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      kill_q     <= '0;
      wb_waddr_q <= '0;
      wb_wdata_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      kill_q   <= kill_d;
      if (wr_en) begin
        wb_waddr_q <= head.waddr;
        wb_wdata_q <= load_data;
      end
    end
  end

`ifdef LSU_WB_BYPASS_EN
  // Same-cycle writeback; the _q registers only supply the held value
  assign bus.wb_we_o    = wr_en;
  assign bus.wb_waddr_o = wr_en ? head.waddr : wb_waddr_q;
  assign bus.wb_wdata_o = wr_en ? load_data : wb_wdata_q;
  assign bus.resp_err_o = err;
`else
  logic wb_we_q, resp_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_we_q    <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      wb_we_q    <= wr_en;
      resp_err_q <= err;
    end
  end

  assign bus.wb_we_o    = wb_we_q;
  assign bus.wb_waddr_o = wb_waddr_q;
  assign bus.wb_wdata_o = wb_wdata_q;
  assign bus.resp_err_o = resp_err_q;
`endif

  assign bus.count_o      = count_q;
  assign bus.busy_o       = (count_q != '0);
  assign bus.push_ready_o = (count_q < DEPTH_C);

endmodule

// File: tb/tb_lsu_wb_queue.sv
// Directed scenarios followed by randomized traffic, checked against a queue-based reference model.
module tb_lsu_wb_queue;

  localparam int DEPTH = 2;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_wb_queue_if #(.CNT_W(CNT_W)) bus ();

  lsu_wb_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit       we;
    bit [4:0] waddr;
    bit [1:0] typ;
    bit       se;
    bit [1:0] off;
    bit       kill;
  } mentry_t;

  mentry_t     mq[$];
  bit          exp_we, exp_err;
  logic [4:0]  last_waddr;
  logic [31:0] last_wdata;
  int          checks = 0;
  int          errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference load formatting: rotate, then mask and extend
  function automatic logic [31:0] ref_load(input logic [31:0] rd, input bit [1:0] typ,
                                           input bit se, input bit [1:0] off);
    int          sh;
    logic [31:0] rot;
    sh  = 8 * int'(off);
    rot = (rd >> sh) | (rd << (32 - sh));
    if (typ == 2'b00) return rot;
    if (typ == 2'b01) return (se && rot[15]) ? (rot | 32'hFFFF0000) : (rot & 32'h0000FFFF);
    return (se && rot[7]) ? (rot | 32'hFFFFFF00) : (rot & 32'h000000FF);
  endfunction

  task automatic check_all(input string tag);
    check_eq({tag, ".we"},    32'(bus.wb_we_o),      32'(exp_we));
    check_eq({tag, ".waddr"}, 32'(bus.wb_waddr_o),   32'(last_waddr));
    check_eq({tag, ".wdata"}, bus.wb_wdata_o,        last_wdata);
    check_eq({tag, ".err"},   32'(bus.resp_err_o),   32'(exp_err));
    check_eq({tag, ".count"}, 32'(bus.count_o),      32'(mq.size()));
    check_eq({tag, ".busy"},  32'(bus.busy_o),       32'(mq.size() != 0));
    check_eq({tag, ".ready"}, 32'(bus.push_ready_o), 32'(mq.size() < DEPTH));
  endtask

  // Called at a falling edge: drive, let the rising edge happen, update model, compare.
  task automatic step(input string tag, input bit p, input bit we, input bit [4:0] wa,
                      input bit [1:0] ty, input bit se, input bit [1:0] off,
                      input bit fl, input bit rv, input logic [31:0] rd);
    int      n0;
    mentry_t e;
    bus.push_i          = p;
    bus.push_we_i       = we;
    bus.push_waddr_i    = wa;
    bus.push_type_i     = ty;
    bus.push_sign_ext_i = se;
    bus.push_offset_i   = off;
    bus.flush_i         = fl;
    bus.rvalid_i        = rv;
    bus.rdata_i         = rd;
    @(posedge clk);
    n0      = mq.size();
    exp_err = rv && (n0 == 0);
    exp_we  = 1'b0;
    if (fl) foreach (mq[i]) mq[i].kill = 1'b1;
    if (rv && n0 > 0) begin
      e = mq.pop_front();
      if (e.we && !e.kill) begin
        exp_we     = 1'b1;
        last_waddr = e.waddr;
        last_wdata = ref_load(rd, e.typ, e.se, e.off);
      end
    end
    if (p && n0 < DEPTH) begin
      e.we = we; e.waddr = wa; e.typ = ty; e.se = se; e.off = off; e.kill = 1'b0;
      mq.push_back(e);
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 5'd0, 2'd0, 0, 2'd0, 0, 0, 32'h0);
  endtask

  initial begin
    bit p, we, se, fl, rv;
    bus.push_i = 0; bus.push_we_i = 0; bus.push_waddr_i = '0; bus.push_type_i = '0;
    bus.push_sign_ext_i = 0; bus.push_offset_i = '0; bus.flush_i = 0; bus.rvalid_i = 0;
    bus.rdata_i = '0;
    exp_we = 0; exp_err = 0; last_waddr = '0; last_wdata = '0;

    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Word load x5
    step("w_push", 1, 1, 5'd5, 2'b00, 0, 2'd0, 0, 0, 32'h0);
    check_eq("w_count1", 32'(bus.count_o), 32'd1);
    step("w_resp", 0, 0, 5'd0, 2'b00, 0, 2'd0, 0, 1, 32'hDEADBEEF);
    check_eq("w_we", 32'(bus.wb_we_o), 32'd1);
    check_eq("w_waddr", 32'(bus.wb_waddr_o), 32'd5);
    check_eq("w_wdata", bus.wb_wdata_o, 32'hDEADBEEF);
    check_eq("w_count0", 32'(bus.count_o), 32'd0);

    // Byte / halfword alignment and extension
    step("lb_push", 1, 1, 5'd6, 2'b10, 1, 2'd3, 0, 0, 32'h0);
    step("lb_resp", 0, 0, 5'd0, 2'b00, 0, 2'd0, 0, 1, 32'h80123456);
    check_eq("lb_wdata", bus.wb_wdata_o, 32'hFFFFFF80);
    step("lbu_push", 1, 1, 5'd6, 2'b10, 0, 2'd3, 0, 0, 32'h0);
    step("lbu_resp", 0, 0, 5'd0, 2'b00, 0, 2'd0, 0, 1, 32'h80123456);
    check_eq("lbu_wdata", bus.wb_wdata_o, 32'h00000080);
    step("lh_push", 1, 1, 5'd7, 2'b01, 1, 2'd2, 0, 0, 32'h0);
    step("lh_resp", 0, 0, 5'd0, 2'b00, 0, 2'd0, 0, 1, 32'h80011234);
    check_eq("lh_wdata", bus.wb_wdata_o, 32'hFFFF8001);

    // Fill, ignored push when full, in-order drain
    step("full_p1", 1, 1, 5'd1, 2'b00, 0, 2'd0, 0, 0, 32'h0);
    step("full_p2", 1, 1, 5'd2, 2'b00, 0, 2'd0, 0, 0, 32'h0);
    check_eq("full_ready", 32'(bus.push_ready_o), 32'd0);
    check_eq("full_count", 32'(bus.count_o), 32'd2);
    step("full_p3", 1, 1, 5'd3, 2'b00, 0, 2'd0, 0, 0, 32'h0);
    check_eq("full_count_hold", 32'(bus.count_o), 32'd2);
    step("full_r1", 0, 0, 5'd0, 2'b00, 0, 2'd0, 0, 1, 32'h11);
    check_eq("full_r1_waddr", 32'(bus.wb_waddr_o), 32'd1);
    check_eq("full_r1_wdata", bus.wb_wdata_o, 32'h11);
    step("full_r2", 0, 0, 5'd0, 2'b00, 0, 2'd0, 0, 1, 32'h22);
    check_eq("full_r2_waddr", 32'(bus.wb_waddr_o), 32'd2);
    check_eq("full_r2_wdata", bus.wb_wdata_o, 32'h22);

    // Flush with same-cycle push
    step("fl_p3", 1, 1, 5'd3, 2'b00, 0, 2'd0, 0, 0, 32'h0);
    step("fl_p4", 1, 1, 5'd4, 2'b00, 0, 2'd0, 1, 0, 32'h0);
    step("fl_r1", 0, 0, 5'd0, 2'b00, 0, 2'd0, 0, 1, 32'hAA);
    check_eq("fl_r1_we", 32'(bus.wb_we_o), 32'd0);
    step("fl_r2", 0, 0, 5'd0, 2'b00, 0, 2'd0, 0, 1, 32'hBB);
    check_eq("fl_r2_we", 32'(bus.wb_we_o), 32'd1);
    check_eq("fl_r2_waddr", 32'(bus.wb_waddr_o), 32'd4);
    check_eq("fl_count", 32'(bus.count_o), 32'd0);

    // Response with nothing outstanding
    step("err_r", 0, 0, 5'd0, 2'b00, 0, 2'd0, 0, 1, 32'h55);
    check_eq("err_pulse", 32'(bus.resp_err_o), 32'd1);
    idle("err_idle");
    check_eq("err_clear", 32'(bus.resp_err_o), 32'd0);

    // Asynchronous reset with two entries outstanding
    step("rst_p1", 1, 1, 5'd8, 2'b00, 0, 2'd0, 0, 0, 32'h0);
    step("rst_p2", 1, 1, 5'd9, 2'b00, 0, 2'd0, 0, 0, 32'h0);
    bus.push_i = 0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_count", 32'(bus.count_o), 32'd0);
    check_eq("rst_ready", 32'(bus.push_ready_o), 32'd1);
    check_eq("rst_busy", 32'(bus.busy_o), 32'd0);
    mq.delete();
    exp_we = 0; exp_err = 0; last_waddr = '0; last_wdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step("rst_orphan", 0, 0, 5'd0, 2'b00, 0, 2'd0, 0, 1, 32'h77);
    check_eq("rst_orphan_err", 32'(bus.resp_err_o), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      p  = ($urandom_range(0, 2) != 0) && ((mq.size() < DEPTH) || ($urandom_range(0, 15) == 0));
      rv = (mq.size() != 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
      fl = ($urandom_range(0, 11) == 0);
      we = ($urandom_range(0, 3) != 0);
      se = $urandom_range(0, 1) != 0;
      step("rand", p, we, 5'($urandom), 2'($urandom), se, 2'($urandom), fl, rv, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
